// File: rtl/wallace_pkg.sv
// Shared constants and elaboration-time helpers for the Wallace-tree multiplier family.
// Row-count arithmetic here drives the shape of the generated reduction tree.
package wallace_pkg;

  localparam int unsigned MIN_WIDTH = 4;
  localparam int unsigned MAX_WIDTH = 32;

  function automatic int unsigned prod_width(input int unsigned width);
    return 2 * width;
  endfunction

  // Rows left after one CSA layer: every group of three collapses to two.
  function automatic int unsigned csa_next_rows(input int unsigned rows);
    return 2 * (rows / 3) + (rows % 3);
  endfunction

  function automatic int unsigned wallace_stages(input int unsigned rows);
    int unsigned n;
    int unsigned stages;
    n      = rows;
    stages = 0;
    while (n > 2) begin
      n      = csa_next_rows(n);
      stages = stages + 1;
    end
    return stages;
  endfunction

  function automatic int unsigned wallace_rows_at(input int unsigned rows,
                                                  input int unsigned stage);
    int unsigned n;
    n = rows;
    for (int unsigned i = 0; i < stage; i++) begin
      n = csa_next_rows(n);
    end
    return n;
  endfunction

endpackage

// File: rtl/wallace_reduce.sv
// Combinational Wallace reduction of WIDTH+1 partial-product rows to two PW-bit rows.
// Each layer applies 3:2 counters to row triples and a 2:2 counter to a leftover pair.
module wallace_reduce
  import wallace_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PW    = prod_width(WIDTH)
) (
  input  logic [WIDTH:0][PW-1:0] rows,
  output logic [PW-1:0]          x,
  output logic [PW-1:0]          y
);

  localparam int unsigned ROWS   = WIDTH + 1;
  localparam int unsigned STAGES = wallace_stages(ROWS);

  for (genvar s = 0; s <= STAGES; s++) begin : g_lvl
    localparam int unsigned N = wallace_rows_at(ROWS, s);
    logic [PW-1:0] r [N];

    if (s == 0) begin : g_in
      for (genvar k = 0; k < N; k++) begin : g_row
        assign r[k] = rows[k];
      end
    end else begin : g_csa
      localparam int unsigned M = wallace_rows_at(ROWS, s - 1);
      localparam int unsigned G = M / 3;
      localparam int unsigned R = M % 3;

      for (genvar g = 0; g < G; g++) begin : g_fa
        logic [PW-1:0] p, q, c;
        assign p          = g_lvl[s-1].r[3*g];
        assign q          = g_lvl[s-1].r[3*g+1];
        assign c          = g_lvl[s-1].r[3*g+2];
        assign r[2*g]     = p ^ q ^ c;
        // Carries weigh one column more; the bit shifted past PW is beyond the product.
        assign r[2*g+1]   = ((p & q) | (p & c) | (q & c)) << 1;
      end

      if (R == 2) begin : g_ha
        logic [PW-1:0] p, q;
        assign p        = g_lvl[s-1].r[3*G];
        assign q        = g_lvl[s-1].r[3*G+1];
        assign r[2*G]   = p ^ q;
        assign r[2*G+1] = (p & q) << 1;
      end else if (R == 1) begin : g_pass
        assign r[2*G] = g_lvl[s-1].r[3*G];
      end
    end
  end

  assign x = g_lvl[STAGES].r[0];
  assign y = g_lvl[STAGES].r[1];

endmodule

// File: rtl/wallace_mult_pipe.sv
// Three-stage pipelined WIDTH x WIDTH multiplier with per-transaction signed/unsigned mode.
// Stages: Baugh-Wooley partial products, Wallace reduction, carry-propagate add.
module wallace_mult_pipe
  import wallace_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PW    = prod_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PW-1:0]    z,
  output logic             out_signed
);

  localparam int unsigned ROWS = WIDTH + 1;

  logic                    v1, v2, v3;
  logic                    rdy1, rdy2, rdy3;
  logic                    mode1, mode2;
  logic [WIDTH:0]          a_ext, b_ext;
  logic [WIDTH:0][PW-1:0]  pp_d, pp_q;
  logic [PW-1:0]           x_d, y_d, x_q, y_q;

  assign rdy3      = !v3 | out_ready;
  assign rdy2      = !v2 | rdy3;
  assign rdy1      = !v1 | rdy2;
  assign in_ready  = rdy1;
  assign out_valid = v3;

  // One extra bit lets both modes share a single signed (WIDTH+1)-bit array.
  assign a_ext = {in_signed & a[WIDTH-1], a};
  assign b_ext = {in_signed & b[WIDTH-1], b};

  // Terms involving exactly one sign bit are complemented; the +2^ROWS correction
  // sits in the free column of row 0, and the +2^(2*ROWS-1) one lies above PW.
  always_comb begin
    pp_d = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      for (int unsigned j = 0; j < ROWS; j++) begin
        if (i + j < PW) begin
          pp_d[i][i+j] = (a_ext[j] & b_ext[i]) ^ ((i == ROWS - 1) != (j == ROWS - 1));
        end
      end
    end
    pp_d[0][ROWS] = 1'b1;
  end

  wallace_reduce #(
    .WIDTH (WIDTH),
    .PW    (PW)
  ) u_reduce (
    .rows (pp_q),
    .x    (x_d),
    .y    (y_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      mode1      <= 1'b0;
      mode2      <= 1'b0;
      pp_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      z          <= '0;
      out_signed <= 1'b0;
    end else begin
      if (rdy1) begin
        v1 <= in_valid;
        if (in_valid) begin
          pp_q  <= pp_d;
          mode1 <= in_signed;
        end
      end
      if (rdy2) begin
        v2 <= v1;
        if (v1) begin
          x_q   <= x_d;
          y_q   <= y_d;
          mode2 <= mode1;
        end
      end
      if (rdy3) begin
        v3 <= v2;
        if (v2) begin
          z          <= x_q + y_q;
          out_signed <= mode2;
        end
      end
    end
  end

  stall_hold_a: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> (out_valid && $stable(z) && $stable(out_signed)));

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Self-checking bench: WIDTH 8 handshake/latency/reset tests plus WIDTH 4 and 32 streams,
// all results scored against a plain-arithmetic product model.
module tb_wallace_mult_pipe;

  typedef struct {
    logic [63:0] p;
    bit          s;
  } exp_t;

  logic clk;
  logic rst_n;

  logic        in_valid8, in_ready8, s8, out_valid8, out_ready8, os8;
  logic [7:0]  a8, b8;
  logic [15:0] z8;

  logic        in_valid4, in_ready4, s4, out_valid4, os4;
  logic [3:0]  a4, b4;
  logic [7:0]  z4;

  logic        in_valid32, in_ready32, s32, out_valid32, os32;
  logic [31:0] a32, b32;
  logic [63:0] z32;

  logic        one;

  int unsigned n_cmp;
  int unsigned n_bad;

  exp_t q8[$], q4[$], q32[$];
  exp_t h8, h4, h32;

  assign one = 1'b1;

  wallace_mult_pipe #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid8),
    .in_ready   (in_ready8),
    .a          (a8),
    .b          (b8),
    .in_signed  (s8),
    .out_valid  (out_valid8),
    .out_ready  (out_ready8),
    .z          (z8),
    .out_signed (os8)
  );

  wallace_mult_pipe #(.WIDTH(4)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid4),
    .in_ready   (in_ready4),
    .a          (a4),
    .b          (b4),
    .in_signed  (s4),
    .out_valid  (out_valid4),
    .out_ready  (one),
    .z          (z4),
    .out_signed (os4)
  );

  wallace_mult_pipe #(.WIDTH(32)) u_dut32 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid32),
    .in_ready   (in_ready32),
    .a          (a32),
    .b          (b32),
    .in_signed  (s32),
    .out_valid  (out_valid32),
    .out_ready  (one),
    .z          (z32),
    .out_signed (os32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Exact product of two w-bit operands, reduced modulo 2^(2w).
  function automatic logic [63:0] ref_mul(input int unsigned w, input logic [63:0] a,
                                          input logic [63:0] b, input bit s);
    logic [63:0] m, pm;
    longint      sa, sb;
    m  = (64'd1 << w) - 64'd1;
    pm = (w >= 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    a  = a & m;
    b  = b & m;
    if (s) begin
      sa = a[w-1] ? longint'(a) - longint'(m) - 64'sd1 : longint'(a);
      sb = b[w-1] ? longint'(b) - longint'(m) - 64'sd1 : longint'(b);
      return 64'(sa * sb) & pm;
    end
    return (a * b) & pm;
  endfunction

  function automatic exp_t mk(input int unsigned w, input logic [63:0] a, input logic [63:0] b,
                              input bit s);
    exp_t e;
    e.p = ref_mul(w, a, b, s);
    e.s = s;
    return e;
  endfunction

  // Scoreboard: occupancy of the model queue gives the expected in_ready.
  always @(negedge clk) begin
    if (!rst_n) begin
      q8.delete();
      q4.delete();
      q32.delete();
    end else begin
      check("d8_in_ready", 64'(in_ready8), 64'((q8.size() < 3) || out_ready8));
      if (q8.size() == 0) begin
        check("d8_idle_valid", 64'(out_valid8), 64'd0);
      end else if (out_valid8 && out_ready8) begin
        h8 = q8.pop_front();
        check("d8_z", 64'(z8), h8.p);
        check("d8_sign", 64'(os8), 64'(h8.s));
      end
      if (in_valid8 && in_ready8) q8.push_back(mk(8, 64'(a8), 64'(b8), s8));

      if (q4.size() == 0) begin
        check("d4_idle_valid", 64'(out_valid4), 64'd0);
      end else if (out_valid4) begin
        h4 = q4.pop_front();
        check("d4_z", 64'(z4), h4.p);
        check("d4_sign", 64'(os4), 64'(h4.s));
      end
      if (in_valid4 && in_ready4) q4.push_back(mk(4, 64'(a4), 64'(b4), s4));

      if (q32.size() == 0) begin
        check("d32_idle_valid", 64'(out_valid32), 64'd0);
      end else if (out_valid32) begin
        h32 = q32.pop_front();
        check("d32_z", z32, h32.p);
        check("d32_sign", 64'(os32), 64'(h32.s));
      end
      if (in_valid32 && in_ready32) q32.push_back(mk(32, 64'(a32), 64'(b32), s32));
    end
  end

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input bit ts,
                      input logic [15:0] exp, input string tag);
    int cyc;
    a8        = ta;
    b8        = tb;
    s8        = ts;
    in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    cyc = 1;
    while (!out_valid8 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd3);
    check({tag, "_z"}, 64'(z8), 64'(exp));
    check({tag, "_sign"}, 64'(os8), 64'(ts));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0]  pa [5];
  logic [7:0]  pb [5];
  bit          ps [5];
  logic [63:0] first_exp;
  logic [31:0] ca [4];
  logic [31:0] cb [4];
  bit          cs [4];
  int          idx;
  int          cyc;
  bit          acc;

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    in_valid8  = 1'b0; a8  = '0; b8  = '0; s8  = 1'b0; out_ready8 = 1'b1;
    in_valid4  = 1'b0; a4  = '0; b4  = '0; s4  = 1'b0;
    in_valid32 = 1'b0; a32 = '0; b32 = '0; s32 = 1'b0;

    #3;
    check("rst_out_valid8", 64'(out_valid8), 64'd0);
    check("rst_z8", 64'(z8), 64'd0);
    check("rst_out_signed8", 64'(os8), 64'd0);
    check("rst_out_valid4", 64'(out_valid4), 64'd0);
    check("rst_z32", z32, 64'd0);
    #9;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready8", 64'(in_ready8), 64'd1);
    @(posedge clk); #1;

    run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_max_max");
    run8(8'h80, 8'h80, 1'b1, 16'h4000, "s_min_min");
    run8(8'hFF, 8'h01, 1'b1, 16'hFFFF, "s_m1_p1");
    run8(8'h7F, 8'h80, 1'b1, 16'hC080, "s_max_min");
    run8(8'hFF, 8'h01, 1'b0, 16'h00FF, "u_ff_01");

    // Back-to-back random stream.
    for (int i = 0; i < 100; i++) begin
      a8        = 8'($urandom);
      b8        = 8'($urandom);
      s8        = 1'($urandom);
      in_valid8 = 1'b1;
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("stream_drained", 64'(q8.size()), 64'd0);

    // Back-pressure: five pairs offered against a stalled consumer.
    for (int k = 0; k < 5; k++) begin
      pa[k] = 8'($urandom);
      pb[k] = 8'($urandom);
      ps[k] = 1'($urandom);
    end
    first_exp  = ref_mul(8, 64'(pa[0]), 64'(pb[0]), ps[0]);
    out_ready8 = 1'b0;
    idx        = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid8 = (idx < 5);
      if (idx < 5) begin
        a8 = pa[idx];
        b8 = pb[idx];
        s8 = ps[idx];
      end
      @(negedge clk);
      acc = in_valid8 && in_ready8;
      if (out_valid8) check("bp_hold_z", 64'(z8), first_exp);
      @(posedge clk); #1;
      if (acc) idx++;
    end
    check("bp_accepted", 64'(idx), 64'd3);
    check("bp_in_ready_low", 64'(in_ready8), 64'd0);
    check("bp_out_valid", 64'(out_valid8), 64'd1);
    out_ready8 = 1'b1;
    cyc = 0;
    while ((idx < 5 || q8.size() != 0) && cyc < 30) begin
      in_valid8 = (idx < 5);
      if (idx < 5) begin
        a8 = pa[idx];
        b8 = pb[idx];
        s8 = ps[idx];
      end
      @(negedge clk);
      acc = in_valid8 && in_ready8;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid8 = 1'b0;
    check("bp_total_accepted", 64'(idx), 64'd5);
    check("bp_drained", 64'(q8.size()), 64'd0);

    // Reset with three transactions in flight.
    out_ready8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a8        = 8'($urandom);
      b8        = 8'($urandom);
      s8        = 1'b1;
      in_valid8 = 1'b1;
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    check("pre_rst_full", 64'(in_ready8), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid8), 64'd0);
    check("midrst_z", 64'(z8), 64'd0);
    check("midrst_out_signed", 64'(os8), 64'd0);
    @(negedge clk);
    #2;
    rst_n      = 1'b1;
    out_ready8 = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    run8(8'd3, 8'd5, 1'b0, 16'd15, "post_rst_3x5");

    // WIDTH=4 exhaustive, both modes.
    for (int i = 0; i < 512; i++) begin
      a4        = 4'(i);
      b4        = 4'(i >> 4);
      s4        = i[8];
      in_valid4 = 1'b1;
      @(negedge clk);
      check("w4_in_ready", 64'(in_ready4), 64'd1);
      @(posedge clk); #1;
    end
    in_valid4 = 1'b0;

    // WIDTH=32 corners then random.
    ca[0] = 32'h8000_0000; cb[0] = 32'h8000_0000; cs[0] = 1'b1;
    ca[1] = 32'h8000_0000; cb[1] = 32'h7FFF_FFFF; cs[1] = 1'b1;
    ca[2] = 32'hFFFF_FFFF; cb[2] = 32'hFFFF_FFFF; cs[2] = 1'b1;
    ca[3] = 32'hFFFF_FFFF; cb[3] = 32'hFFFF_FFFF; cs[3] = 1'b0;
    for (int i = 0; i < 204; i++) begin
      if (i < 4) begin
        a32 = ca[i];
        b32 = cb[i];
        s32 = cs[i];
      end else begin
        a32 = $urandom;
        b32 = $urandom;
        s32 = 1'($urandom);
      end
      in_valid32 = 1'b1;
      @(posedge clk); #1;
    end
    in_valid32 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("w4_drained", 64'(q4.size()), 64'd0);
    check("w32_drained", 64'(q32.size()), 64'd0);
    check("w32_min_min_model", ref_mul(32, 64'h8000_0000, 64'h8000_0000, 1'b1),
          64'h4000_0000_0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wallace_mult_pipe.md
Name: wallace_mult_pipe

Overview:
Parametrised, pipelined Wallace-tree multiplier for WIDTH x WIDTH operands with per-transaction signed/unsigned mode. It is the successor of the fixed 8x8 combinational multiplier. Operands enter through a valid/ready handshake. The exact 2*WIDTH-bit product leaves through a valid/ready handshake after a fixed three-stage pipeline, with full back-pressure. It sits between operand sources (DSP datapath, MAC controller) and result consumers.

Parameters:
WIDTH, 8, operand width in bits; legal range 4..32.
PW, 2*WIDTH, product width; derived, must not be overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block accepts the operand pair this cycle
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
in_signed  input  1  1 = two's-complement operands; 0 = unsigned
out_valid  output  1  product valid
out_ready  input  1  consumer accepts the product this cycle
z  output  PW  product
out_signed  output  1  mode of the transaction on z

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). While rst_n=0, all stage valid flags are 0, out_valid=0, z=0 and out_signed=0. in_ready=1 combinationally once rst_n=1.
- Reset mid-operation: all in-flight transactions are discarded. No partial result is ever presented.
- Arithmetic:
  - z = a*b exactly, modulo 2^PW. No overflow is possible.
  - Unsigned: operands are zero-extended. Signed: operands are sign-extended.
  - Implementation: Baugh-Wooley partial products on (WIDTH+1)-bit extended operands (extension bit = in_signed & msb). Only the low PW bits are kept.
- Stage 1 (S1) registers: WIDTH+1 partial-product rows, in_signed, v1.
- Stage 2 (S2):
  - Wallace reduction of the S1 rows with 3:2 and 2:2 counters down to two rows, x and y, each PW bits.
  - Registers x, y, mode, v2.
- Stage 3 (S3): z = x + y (carry-propagate add, carry-out discarded). Registers z, out_signed, v3. out_valid = v3.
- Latency: 3 cycles from input handshake to out_valid, with out_ready held at 1. Throughput: 1 product per cycle.
- Handshake:
  - Transfer occurs when valid & ready are both high on a rising edge.
  - rdy3 = !v3 | out_ready; rdy2 = !v2 | rdy3; rdy1 = !v1 | rdy2; in_ready = rdy1. This is a combinational chain with no bubbles inserted.
  - A stage loads when its ready is high. Its valid flag becomes the upstream valid.
  - A stage holds its contents when its ready is low.
- Stall: while out_valid=1 and out_ready=0, z and out_signed are stable. The pipeline fills to at most 3 transactions, then in_ready=0.
- Simultaneous events:
  - Full pipeline with out_ready=1 and in_valid=1: all stages advance and the new pair is accepted in the same cycle.
  - in_valid=0: bubbles propagate and the stage valid flags clear.
- Operands are sampled only on an input transfer. a/b/in_signed may change freely otherwise.
- Ordering: results emerge in strict acceptance order. No reordering, no drops.

Decomposition:
- Shared package wallace_pkg:
  - MIN_WIDTH=4, MAX_WIDTH=32.
  - Function for the Wallace tree stage count versus row count.
  - Localparam helper for PW.
- Sub-module wallace_reduce:
  - Purely combinational.
  - Parametrised by WIDTH.
  - Takes the WIDTH+1 partial-product rows and outputs two PW-bit rows x, y.
  - Generalises the existing 8x8 reduction tree and is reusable by the MAC block.
- The top module holds the handshake, stage registers, partial-product generation and the final adder.

Test Plan:
1. WIDTH=8, unsigned: a=0xFF, b=0xFF, out_ready=1 -> out_valid 3 cycles later, z=0xFE01, out_signed=0.
2. WIDTH=8, signed:
   - a=0x80, b=0x80 -> z=0x4000.
   - a=0xFF, b=0x01 -> z=0xFFFF.
   - a=0x7F, b=0x80 -> z=0xC080.
   - Same bits unsigned: a=0xFF, b=0x01 -> z=0x00FF.
3. Back-to-back stream: 100 random pairs, in_valid=1 continuously, out_ready=1 -> one result per cycle, in order, all matching the reference model, in_ready never low.
4. Back-pressure:
   - out_ready=0 with 5 pairs offered -> exactly 3 accepted, then in_ready=0; z holds the first product stable.
   - Release out_ready -> the remaining pairs drain in order with no loss or duplicates.
5. Reset mid-operation: 3 transactions in flight, pulse rst_n low asynchronously between clock edges -> out_valid=0 and z=0 immediately. After release, no stale results appear, and a new pair 3x5 yields z=15 after 3 cycles.
6. WIDTH=4 and WIDTH=32 builds:
   - Signed corners: min*min, min*max, -1*-1.
   - Unsigned: max*max.
   - Exhaustive check for WIDTH=4 (both modes, 512 cases).
